// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core with one handshaked memory port for fetch, load and store.
// Optional macro MULTICYCLE_BRANCH_EXT_EN adds bne/blt/bge/bltu/bgeu; without it only beq is legal.
module multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREG     = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        illegal,
    output logic [2:0]  state_o
);
    localparam int RW = $clog2(NREG);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;
    localparam logic [2:0] TRAP   = 3'd6;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [2:0]         state;
    logic [31:0]        pc;
    logic [31:0]        ir;
    logic signed [31:0] a, b, imm, r;
    logic [31:0]        rf [NREG];

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    function automatic logic reg_ok(input logic [4:0] idx);
        return int'(idx) < NREG;
    endfunction

    function automatic logic br_f3_ok(input logic [2:0] fn);
`ifdef MULTICYCLE_BRANCH_EXT_EN
        return (fn != 3'b010) && (fn != 3'b011);
`else
        return fn == 3'b000;
`endif
    endfunction

    function automatic logic branch_taken(input logic [2:0] fn, input logic signed [31:0] x,
                                          input logic signed [31:0] y);
`ifdef MULTICYCLE_BRANCH_EXT_EN
        case (fn)
            3'b000:  return x == y;
            3'b001:  return x != y;
            3'b100:  return x < y;
            3'b101:  return x >= y;
            3'b110:  return $unsigned(x) < $unsigned(y);
            3'b111:  return $unsigned(x) >= $unsigned(y);
            default: return 1'b0;
        endcase
`else
        return (fn == 3'b000) && (x == y);
`endif
    endfunction

    function automatic logic signed [31:0] alu(input logic signed [31:0] x, input logic signed [31:0] y,
                                               input logic [2:0] fn, input logic alt);
        case (fn)
            3'b000:  return alt ? x - y : x + y;
            3'b001:  return x << y[4:0];
            3'b010:  return {31'd0, x < y};
            3'b011:  return {31'd0, $unsigned(x) < $unsigned(y)};
            3'b100:  return x ^ y;
            3'b101:  return alt ? x >>> y[4:0] : $signed($unsigned(x) >> y[4:0]);
            3'b110:  return x | y;
            default: return x & y;
        endcase
    endfunction

    // Decode: immediate format and legality, including register indices beyond NREG.
    logic signed [31:0] imm_dec;
    logic               op_ok, use_rd, use_rs1, use_rs2, legal;
    always_comb begin
        imm_dec = '0;
        op_ok   = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_REG: begin
                op_ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                {use_rd, use_rs1, use_rs2} = 3'b111;
            end
            OP_IMM: begin
                imm_dec = {{20{ir[31]}}, ir[31:20]};
                op_ok   = (f3 == 3'b001) ? (f7 == 7'h00) :
                          (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                {use_rd, use_rs1} = 2'b11;
            end
            OP_LOAD: begin
                imm_dec = {{20{ir[31]}}, ir[31:20]};
                op_ok   = f3 == 3'b010;
                {use_rd, use_rs1} = 2'b11;
            end
            OP_STORE: begin
                imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                op_ok   = f3 == 3'b010;
                {use_rs1, use_rs2} = 2'b11;
            end
            OP_BRANCH: begin
                imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                op_ok   = br_f3_ok(f3);
                {use_rs1, use_rs2} = 2'b11;
            end
            OP_JAL: begin
                imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
                op_ok   = 1'b1;
                use_rd  = 1'b1;
            end
            OP_JALR: begin
                imm_dec = {{20{ir[31]}}, ir[31:20]};
                op_ok   = f3 == 3'b000;
                {use_rd, use_rs1} = 2'b11;
            end
            OP_LUI, OP_AUIPC: begin
                imm_dec = {ir[31:12], 12'd0};
                op_ok   = 1'b1;
                use_rd  = 1'b1;
            end
            default: ;
        endcase
        legal = op_ok && (!use_rd || reg_ok(rd)) && (!use_rs1 || reg_ok(rs1)) && (!use_rs2 || reg_ok(rs2));
    end

    logic [31:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1[RW-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2[RW-1:0]];

    // Execute: result, next PC and next state; misaligned data or jump addresses trap.
    logic               alt;
    logic signed [31:0] exec_r;
    logic [31:0]        exec_pc, pc_seq, pc_tgt, addr_sum, jalr_tgt;
    logic [2:0]         exec_next;
    always_comb begin
        alt       = (opcode == OP_REG && ir[30]) || (opcode == OP_IMM && f3 == 3'b101 && ir[30]);
        pc_seq    = pc + 32'd4;
        pc_tgt    = pc + imm;
        addr_sum  = a + imm;
        jalr_tgt  = {addr_sum[31:1], 1'b0};
        exec_r    = alu(a, (opcode == OP_REG) ? b : imm, f3, alt);
        exec_pc   = pc_seq;
        exec_next = WB;
        case (opcode)
            OP_LUI:   exec_r = imm;
            OP_AUIPC: exec_r = pc_tgt;
            OP_LOAD, OP_STORE: begin
                exec_r    = addr_sum;
                exec_pc   = pc;
                exec_next = (addr_sum[1:0] != 2'b00) ? TRAP : MEM;
            end
            OP_BRANCH: begin
                exec_next = FETCH;
                if (branch_taken(f3, a, b)) begin
                    exec_pc = pc_tgt;
                    if (pc_tgt[1:0] != 2'b00) exec_next = TRAP;
                end
            end
            OP_JAL: begin
                exec_r  = pc_seq;
                exec_pc = pc_tgt;
                if (pc_tgt[1:0] != 2'b00) exec_next = TRAP;
            end
            OP_JALR: begin
                exec_r  = pc_seq;
                exec_pc = jalr_tgt;
                if (jalr_tgt[1:0] != 2'b00) exec_next = TRAP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            case (state)
                IDLE:   state <= FETCH;
                FETCH:  if (mem_ready) state <= DECODE;
                DECODE: state <= legal ? EXEC : TRAP;
                EXEC: begin
                    state <= exec_next;
                    pc    <= exec_pc;
                end
                MEM: if (mem_ready) begin
                    pc    <= pc + 32'd4;
                    state <= (opcode == OP_LOAD) ? WB : FETCH;
                end
                WB:      state <= FETCH;
                default: state <= TRAP;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (state == FETCH && mem_ready) ir <= mem_rdata;
        if (state == DECODE) begin
            a   <= rs1_val;
            b   <= rs2_val;
            imm <= imm_dec;
        end
        if (state == EXEC) r <= exec_r;
        if (state == MEM && mem_ready && opcode == OP_LOAD) r <= mem_rdata;
        if (state == WB && rd != 5'd0) rf[rd[RW-1:0]] <= r;
    end

    assign mem_req   = (state == FETCH) || (state == MEM);
    assign mem_we    = (state == MEM) && (opcode == OP_STORE);
    assign mem_addr  = (state == MEM) ? r : pc;
    assign mem_wdata = mem_we ? b : 32'd0;
    assign illegal   = state == TRAP;
    assign state_o   = state;
endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: directed programs, expected memory transfers queued, monitor compares.
module tb_multicycle_core;
    logic        CLK = 1'b0;
    logic        RESET, mem_req, mem_we, mem_ready, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  state_o;
    logic        r16, req16, we16, ready16, ill16;
    logic [31:0] addr16, wdata16, rdata16;
    logic [2:0]  st16;

    always #5 CLK = ~CLK;

    multicycle_core #(.RESET_PC(32'h100), .NREG(32)) u_dut (
        .CLK(CLK), .RESET(RESET), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .illegal(illegal), .state_o(state_o));

    multicycle_core #(.RESET_PC(32'h200), .NREG(16)) u_dut16 (
        .CLK(CLK), .RESET(r16), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
        .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ready(ready16),
        .illegal(ill16), .state_o(st16));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          dcyc;
    } xfer_t;

    xfer_t       sbq[$];
    logic [31:0] mem [0:1023];
    int          checks = 0, failures = 0, cyc = 0, wait_n = 0, last_acc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory model: wait_n stall cycles per access; stores commit after acceptance.
    initial begin
        logic        pend;
        logic [31:0] paddr, pdata;
        int          wcnt;
        pend = 1'b0; wcnt = 0; mem_ready = 1'b0; mem_rdata = '0; paddr = '0; pdata = '0;
        forever begin
            @(negedge CLK);
            if (pend) begin
                mem[paddr[11:2]] = pdata;
                pend = 1'b0;
            end
            mem_rdata = mem[mem_addr[11:2]];
            if (mem_req && !RESET) begin
                if (wcnt < wait_n) begin
                    mem_ready = 1'b0;
                    wcnt++;
                end else begin
                    mem_ready = 1'b1;
                    wcnt = 0;
                    if (mem_we) begin
                        pend = 1'b1; paddr = mem_addr; pdata = mem_wdata;
                    end
                end
            end else begin
                mem_ready = (wait_n == 0);
                wcnt = 0;
            end
        end
    end

    // Monitor: every requesting cycle is compared with the queue head; it is popped on acceptance.
    initial begin
        xfer_t e;
        logic  ok;
        forever begin
            @(negedge CLK);
            #3;
            if (!RESET && mem_req) begin
                if (sbq.size() == 0) begin
                    if (mem_ready) begin
                        checks++; failures++;
                        $display("FAIL unexpected_xfer actual addr=%h we=%b required none", mem_addr, mem_we);
                        last_acc = cyc;
                    end
                end else begin
                    e  = sbq[0];
                    ok = (mem_addr == e.addr) && (mem_we == e.we) && (!e.we || mem_wdata == e.data);
                    checks++;
                    if (!ok) begin
                        failures++;
                        $display("FAIL xfer actual addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                                 mem_addr, mem_we, mem_wdata, e.addr, e.we, e.data);
                    end
                    if (mem_ready) begin
                        void'(sbq.pop_front());
                        if (e.dcyc >= 0) check("xfer_gap", cyc - last_acc, e.dcyc);
                        last_acc = cyc;
                    end
                end
            end
        end
    end

    localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011, OPL = 7'b0000011;

    function automatic logic [31:0] enc_i(int im, int s1, int fn, int d, logic [6:0] op);
        return {im[11:0], s1[4:0], fn[2:0], d[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(int fn7, int s2, int s1, int fn, int d);
        return {fn7[6:0], s2[4:0], s1[4:0], fn[2:0], d[4:0], OPR};
    endfunction
    function automatic logic [31:0] enc_sw(int s2, int im, int s1);
        return {im[11:5], s2[4:0], s1[4:0], 3'b010, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(int im, int s2, int s1, int fn);
        return {im[12], im[10:5], s2[4:0], s1[4:0], fn[2:0], im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_lui(int d, int im20);
        return {im20[19:0], d[4:0], 7'b0110111};
    endfunction
    function automatic logic [31:0] enc_jal(int d, int im);
        return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'b1101111};
    endfunction

    task automatic put(input int addr, input logic [31:0] w);
        mem[addr[11:2]] = w;
    endtask
    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        sbq.delete();
    endtask
    task automatic exp_f(input int addr, input int d);
        xfer_t x;
        x.we = 1'b0; x.addr = addr; x.data = '0; x.dcyc = d;
        sbq.push_back(x);
    endtask
    task automatic exp_w(input int addr, input logic [31:0] data, input int d);
        xfer_t x;
        x.we = 1'b1; x.addr = addr; x.data = data; x.dcyc = d;
        sbq.push_back(x);
    endtask

    task automatic run(input int waits, input bit chk_reset);
        wait_n = waits;
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK);
        if (chk_reset) begin
            #3;
            check("rst_req", mem_req, 1'b0);
            check("rst_we", mem_we, 1'b0);
            check("rst_addr", mem_addr, 32'h100);
            check("rst_wdata", mem_wdata, 32'h0);
            check("rst_illegal", illegal, 1'b0);
            check("rst_state", state_o, 3'd0);
        end
        @(negedge CLK); RESET = 1'b0;
        if (chk_reset) begin
            #3;
            check("idle_req", mem_req, 1'b0);
            @(negedge CLK); #3;
            check("first_req", mem_req, 1'b1);
            check("first_addr", mem_addr, 32'h100);
        end
        for (int i = 0; i < 400 && !illegal; i++) @(negedge CLK);
        check("halt_reached", illegal, 1'b1);
        repeat (4) @(negedge CLK);
        check("queue_drained", sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        int reqs;
        RESET = 1'b1; r16 = 1'b1; ready16 = 1'b1;
        rdata16 = enc_r(0, 2, 1, 0, 17);
        repeat (2) @(negedge CLK);

        // addi then store of x1; zero word ends each program via trap
        clear_mem();
        put(32'h100, enc_i(5, 0, 0, 1, OPI));
        put(32'h104, enc_sw(1, 32'h40, 0));
        exp_f(32'h100, -1); exp_f(32'h104, 4); exp_w(32'h40, 32'd5, 3); exp_f(32'h108, 1);
        run(0, 1'b1);

        clear_mem();
        put(32'h100, enc_lui(1, 32'h80000));
        put(32'h104, enc_i(-1, 0, 0, 2, OPI));
        put(32'h108, enc_r(0, 2, 1, 0, 3));
        put(32'h10C, enc_r(0, 0, 1, 2, 4));
        put(32'h110, enc_r(0, 0, 1, 3, 5));
        put(32'h114, enc_i(32'h404, 1, 5, 6, OPI));
        put(32'h118, enc_r(0, 2, 2, 1, 7));
        put(32'h11C, enc_sw(3, 32'h40, 0));
        put(32'h120, enc_sw(4, 32'h44, 0));
        put(32'h124, enc_sw(5, 32'h48, 0));
        put(32'h128, enc_sw(6, 32'h4C, 0));
        put(32'h12C, enc_sw(7, 32'h50, 0));
        exp_f(32'h100, -1);
        for (int k = 1; k < 8; k++) exp_f(32'h100 + 4 * k, 4);
        exp_w(32'h40, 32'h7FFF_FFFF, 3); exp_f(32'h120, 1);
        exp_w(32'h44, 32'h1, 3);         exp_f(32'h124, 1);
        exp_w(32'h48, 32'h0, 3);         exp_f(32'h128, 1);
        exp_w(32'h4C, 32'hF800_0000, 3); exp_f(32'h12C, 1);
        exp_w(32'h50, 32'h8000_0000, 3); exp_f(32'h130, 1);
        run(0, 1'b0);

        // three wait states on every access; lw spans 6 + 5 = 11 cycles fetch to fetch
        clear_mem();
        put(32'h100, enc_lui(1, 32'h80000));
        put(32'h104, enc_i(-1, 1, 0, 3, OPI));
        put(32'h108, enc_sw(3, 8, 0));
        put(32'h10C, enc_i(8, 0, 2, 6, OPL));
        put(32'h110, enc_sw(6, 32'h40, 0));
        exp_f(32'h100, -1); exp_f(32'h104, 7); exp_f(32'h108, 7);
        exp_w(32'h8, 32'h7FFF_FFFF, 6); exp_f(32'h10C, 4);
        exp_f(32'h8, 6); exp_f(32'h110, 5);
        exp_w(32'h40, 32'h7FFF_FFFF, 6); exp_f(32'h114, 4);
        run(3, 1'b0);

        clear_mem();
        put(32'h100, enc_i(7, 0, 0, 0, OPI));
        put(32'h104, enc_jal(0, 12));
        put(32'h108, enc_jal(0, 24));
        put(32'h110, enc_b(-8, 0, 0, 0));
        put(32'h120, enc_jal(1, 16));
        put(32'h124, enc_sw(1, 32'h40, 0));
        put(32'h128, enc_sw(0, 32'h44, 0));
        put(32'h130, enc_i(0, 1, 0, 0, 7'b1100111));
        exp_f(32'h100, -1); exp_f(32'h104, 4); exp_f(32'h110, 4); exp_f(32'h108, 3);
        exp_f(32'h120, 4); exp_f(32'h130, 4); exp_f(32'h124, 4);
        exp_w(32'h40, 32'h124, 3); exp_f(32'h128, 1);
        exp_w(32'h44, 32'h0, 3);   exp_f(32'h12C, 1);
        run(0, 1'b0);

        clear_mem();
        put(32'h100, enc_i(1, 0, 0, 1, OPI));
        put(32'h104, enc_i(2, 0, 0, 2, OPI));
        put(32'h108, enc_b(8, 2, 1, 1));
        put(32'h10C, enc_sw(1, 32'h40, 0));
        put(32'h110, enc_sw(2, 32'h44, 0));
        exp_f(32'h100, -1); exp_f(32'h104, 4); exp_f(32'h108, 4);
`ifdef MULTICYCLE_BRANCH_EXT_EN
        exp_f(32'h110, 3); exp_w(32'h44, 32'h2, 3); exp_f(32'h114, 1);
`endif
        run(0, 1'b0);

        // misaligned lw address and misaligned jalr target: trap with no access issued
        clear_mem();
        put(32'h100, enc_i(2, 0, 2, 7, OPL));
        exp_f(32'h100, -1);
        run(0, 1'b0);
        clear_mem();
        put(32'h100, enc_i(2, 0, 0, 0, 7'b1100111));
        exp_f(32'h100, -1);
        run(0, 1'b0);

        // NREG=16 core: rd index 17 is illegal
        @(negedge CLK); #3;
        check("r16_rst_req", req16, 1'b0);
        check("r16_rst_addr", addr16, 32'h200);
        check("r16_rst_illegal", ill16, 1'b0);
        @(negedge CLK); r16 = 1'b0;
        repeat (5) @(negedge CLK);
        #3;
        check("r16_illegal", ill16, 1'b1);
        check("r16_state", st16, 3'd6);
        reqs = 0;
        repeat (8) begin
            @(negedge CLK); #3;
            if (req16) reqs++;
        end
        check("r16_trap_quiet", reqs, 0);
        @(negedge CLK); r16 = 1'b1;
        @(negedge CLK); r16 = 1'b0;
        #3;
        check("r16_restart_idle", st16, 3'd0);
        check("r16_restart_illegal", ill16, 1'b0);
        @(negedge CLK); #3;
        check("r16_restart_req", req16, 1'b1);
        check("r16_restart_addr", addr16, 32'h200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
